// File: rtl/div_request_ctrl.sv
// div_request_ctrl: RV32M divide front-end.
// Accepts DIV/DIVU/REM/REMU requests and settles divide-by-zero and signed
// overflow locally. Every other request goes to an unsigned, non-resettable
// restoring divider core as operand magnitudes. The core result is
// sign-corrected and returned over a valid/ready response handshake.
// Pipeline flushes abort the request in flight. A flush or reset that lands
// mid-division is drained, so the core is never restarted while busy.
module div_request_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    // request handshake
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    // response handshake
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WIDTH-1:0] resp_data_o,
    // pipeline abort
    input  logic             flush_i,
    // divider core
    output logic             div_start_o,
    output logic [WIDTH-1:0] div_numerator_o,
    output logic [WIDTH-1:0] div_denominator_o,
    input  logic [WIDTH-1:0] div_quotient_i,
    input  logic [WIDTH-1:0] div_remainder_i,
    input  logic             div_done_i
);

    localparam logic [2:0] S_DRAIN = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2:0]       state_q, state_d;
    logic             op_rem_q, op_rem_d;
    logic             neg1_q, neg1_d;
    logic             neg2_q, neg2_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;

    logic             rs1_neg;
    logic             rs2_neg;
    logic             div_zero;
    logic             signed_ovf;
    logic [WIDTH-1:0] quo_fixed;
    logic [WIDTH-1:0] rem_fixed;

    // Classify the incoming request and sign-correct the core result.
    always_comb begin
        // The sign flag is the operand MSB for signed ops, 0 for unsigned.
        rs1_neg    = ~funct3_i[0] & rs1_i[WIDTH-1];
        rs2_neg    = ~funct3_i[0] & rs2_i[WIDTH-1];
        div_zero   = (rs2_i == '0);
        signed_ovf = ~funct3_i[0] & (rs1_i == MIN_NEG) & (rs2_i == '1);
        quo_fixed  = (neg1_q ^ neg2_q) ? (~div_quotient_i + 1'b1) : div_quotient_i;
        rem_fixed  = neg1_q ? (~div_remainder_i + 1'b1) : div_remainder_i;
    end

    // Next-state logic for the sequencing FSM and its datapath registers.
    always_comb begin
        // NOTE: every signal gets a default first so that no path leaves one
        // unassigned; an unassigned path would infer a latch.
        state_d     = state_q;
        op_rem_d    = op_rem_q;
        neg1_d      = neg1_q;
        neg2_d      = neg2_q;
        num_d       = num_q;
        den_d       = den_q;
        resp_data_d = resp_data_q;

        case (state_q)
            S_DRAIN: begin
                // The core is not reset, so wait until it reports idle.
                if (div_done_i) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (req_valid_i && !flush_i) begin
                    op_rem_d = funct3_i[1];
                    neg1_d   = rs1_neg;
                    neg2_d   = rs2_neg;
                    num_d    = rs1_neg ? (~rs1_i + 1'b1) : rs1_i;
                    den_d    = rs2_neg ? (~rs2_i + 1'b1) : rs2_i;
                    if (div_zero) begin
                        resp_data_d = funct3_i[1] ? rs1_i : '1;
                        state_d     = S_RESP;
                    end else if (signed_ovf) begin
                        resp_data_d = funct3_i[1] ? '0 : MIN_NEG;
                        state_d     = S_RESP;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                // The core has not started yet, so a flush can return straight to IDLE.
                state_d = flush_i ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (flush_i) begin
                    state_d = S_DRAIN;
                end else if (div_done_i) begin
                    resp_data_d = op_rem_q ? rem_fixed : quo_fixed;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (flush_i || resp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_DRAIN;
        endcase
    end

    // State and datapath registers. Reset enters DRAIN because the core may be busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_DRAIN;
            op_rem_q    <= 1'b0;
            neg1_q      <= 1'b0;
            neg2_q      <= 1'b0;
            num_q       <= '0;
            den_q       <= '0;
            resp_data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments give every flop its value from
            // before this edge, so the flops cannot race one another.
            state_q     <= state_d;
            op_rem_q    <= op_rem_d;
            neg1_q      <= neg1_d;
            neg2_q      <= neg2_d;
            num_q       <= num_d;
            den_q       <= den_d;
            resp_data_q <= resp_data_d;
        end
    end

    // Handshake outputs are decoded from the state. A flush suppresses the
    // start pulse and withdraws a pending response in the same cycle.
    always_comb begin
        req_ready_o       = (state_q == S_IDLE) & ~flush_i;
        div_start_o       = (state_q == S_START) & ~flush_i;
        resp_valid_o      = (state_q == S_RESP) & ~flush_i;
        resp_data_o       = resp_data_q;
        div_numerator_o   = num_q;
        div_denominator_o = den_q;
    end

endmodule

// File: tb/tb_div_request_ctrl.sv
// Testbench for div_request_ctrl.
// A behavioural model of the non-resettable divider core (32 busy cycles,
// then done) is attached to the core port. Expected results come from a
// stimulus table and go into a scoreboard queue. Hand-written sequences
// cover response back-pressure, flush and reset during a division.
module tb_div_request_ctrl;

    localparam int WIDTH = 32;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid_i = 1'b0;
    logic             req_ready_o;
    logic [2:0]       funct3_i = '0;
    logic [WIDTH-1:0] rs1_i = '0;
    logic [WIDTH-1:0] rs2_i = '0;
    logic             resp_valid_o;
    logic             resp_ready_i = 1'b0;
    logic [WIDTH-1:0] resp_data_o;
    logic             flush_i = 1'b0;
    logic             div_start_o;
    logic [WIDTH-1:0] div_numerator_o;
    logic [WIDTH-1:0] div_denominator_o;
    logic [WIDTH-1:0] div_quotient_i;
    logic [WIDTH-1:0] div_remainder_i;
    logic             div_done_i;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [WIDTH-1:0] sb_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    div_request_ctrl #(.WIDTH(WIDTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .funct3_i          (funct3_i),
        .rs1_i             (rs1_i),
        .rs2_i             (rs2_i),
        .resp_valid_o      (resp_valid_o),
        .resp_ready_i      (resp_ready_i),
        .resp_data_o       (resp_data_o),
        .flush_i           (flush_i),
        .div_start_o       (div_start_o),
        .div_numerator_o   (div_numerator_o),
        .div_denominator_o (div_denominator_o),
        .div_quotient_i    (div_quotient_i),
        .div_remainder_i   (div_remainder_i),
        .div_done_i        (div_done_i)
    );

    // Core model: no reset. Busy for WIDTH cycles after the start edge, done
    // in the final cycle, and done stays high while idle.
    int               core_cnt = 0;
    int               start_cnt = 0;
    int               start_busy_err = 0;
    logic [WIDTH-1:0] core_q = '0;
    logic [WIDTH-1:0] core_r = '0;

    always @(posedge clk) begin
        if (div_start_o) begin
            start_cnt <= start_cnt + 1;
            if (core_cnt > 1) start_busy_err <= start_busy_err + 1;
            core_cnt <= WIDTH + 1;
            core_q   <= (div_denominator_o == '0) ? '1 : div_numerator_o / div_denominator_o;
            core_r   <= (div_denominator_o == '0) ? div_numerator_o : div_numerator_o % div_denominator_o;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
        end
    end

    assign div_done_i      = (core_cnt <= 1);
    assign div_quotient_i  = div_done_i ? core_q : 32'hDEAD_BEEF;
    assign div_remainder_i = div_done_i ? core_r : 32'hBADC_0FFE;

    typedef struct {
        logic [2:0]       f3;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp;
        int               lat;
        int               starts;
        int               hold;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_req_ready", {31'd0, req_ready_o}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
        check("rst_div_start", {31'd0, div_start_o}, 32'd0);
        check("rst_resp_data", resp_data_o, 32'd0);
        check("rst_numerator", div_numerator_o, 32'd0);
        check("rst_denominator", div_denominator_o, 32'd0);
    endtask

    // Present a request and hold it until it is accepted. acc is the number
    // of clock edges seen before the accept edge T.
    task automatic do_req(input logic [2:0] f3, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp, input bit push, output int acc);
        int n;
        n = 0;
        acc = cyc;
        @(negedge clk);
        req_valid_i = 1'b1;
        funct3_i    = f3;
        rs1_i       = a;
        rs2_i       = b;
        #1;
        while (!req_ready_o && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready_o) begin
            check("req_accept_timeout", 32'd0, 32'd1);
        end else begin
            acc = cyc;
            if (push) sb_q.push_back(exp);
        end
        @(posedge clk);
        #1 req_valid_i = 1'b0;
    endtask

    // Wait for the response, check latency and data, optionally hold off the
    // consumer for 'hold' cycles, take it, then check that req_ready follows.
    task automatic wait_resp(input int acc, input int exp_lat, input int hold);
        int               n;
        logic [WIDTH-1:0] d0;
        logic [WIDTH-1:0] exp;
        n = 0;
        @(negedge clk);
        while (!resp_valid_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxx_xxxx;
        if (!resp_valid_o) begin
            check("resp_timeout", 32'd0, 32'd1);
            return;
        end
        check("latency", cyc - acc, exp_lat);
        check("resp_data", resp_data_o, exp);
        d0 = resp_data_o;
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", {31'd0, resp_valid_o}, 32'd1);
            check("hold_data", resp_data_o, d0);
            check("hold_no_accept", {31'd0, req_ready_o}, 32'd0);
            @(negedge clk);
        end
        if (hold > 0) check("hold_data_final", resp_data_o, d0);
        resp_ready_i = 1'b1;
        @(posedge clk);
        #1 resp_ready_i = 1'b0;
        @(negedge clk);
        check("ready_after_take", {31'd0, req_ready_o}, 32'd1);
        check("valid_after_take", {31'd0, resp_valid_o}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int acc;
        int s0;
        s0 = start_cnt;
        do_req(v.f3, v.a, v.b, v.exp, 1'b1, acc);
        wait_resp(acc, v.lat, v.hold);
        check("start_pulses", start_cnt - s0, v.starts);
    endtask

    // Check that req_ready stays low and no response appears until the core
    // reports done, then that req_ready rises one cycle later.
    task automatic expect_drain(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            check({tag, "_no_resp"}, {31'd0, resp_valid_o}, 32'd0);
            check({tag, "_ready_low"}, {31'd0, req_ready_o}, 32'd0);
            n++;
        end while (!div_done_i && n < 60);
        check({tag, "_done_seen"}, {31'd0, div_done_i}, 32'd1);
        @(negedge clk);
        check({tag, "_ready_after_done"}, {31'd0, req_ready_o}, 32'd1);
    endtask

    initial begin
        vec_t v;
        int   acc;
        int   s0;

        vecs[0]  = '{F_DIV,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 35, 1, 0};
        vecs[1]  = '{F_REM,  32'd7,          32'hFFFF_FFFE, 32'd1,         35, 1, 0};
        vecs[2]  = '{F_DIV,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 35, 1, 0};
        vecs[3]  = '{F_REM,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 35, 1, 0};
        vecs[4]  = '{F_DIVU, 32'hFFFF_FFFF,  32'h10,        32'h0FFF_FFFF, 35, 1, 0};
        vecs[5]  = '{F_REMU, 32'hFFFF_FFFF,  32'h10,        32'hF,         35, 1, 0};
        vecs[6]  = '{F_DIV,  32'd5,          32'd0,         32'hFFFF_FFFF, 1,  0, 0};
        vecs[7]  = '{F_REM,  32'd5,          32'd0,         32'd5,         1,  0, 0};
        vecs[8]  = '{F_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  0, 0};
        vecs[9]  = '{F_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  0, 0};
        vecs[10] = '{F_DIVU, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  0, 0};
        vecs[11] = '{F_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         35, 1, 0};
        vecs[12] = '{F_REMU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 35, 1, 0};
        vecs[13] = '{F_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        35, 1, 3};

        // Power-on reset with the core idle.
        repeat (3) @(negedge clk);
        #1 check_reset_vals();
        rst_n = 1'b1;
        #1 check("ready_at_release", {31'd0, req_ready_o}, 32'd0);
        @(negedge clk);
        check("ready_one_after_release", {31'd0, req_ready_o}, 32'd1);

        // Table-driven operations; the last one holds the consumer off for 3 cycles.
        for (int i = 0; i < 14; i++) begin
            v = vecs[i];
            run_vec(v);
        end

        // A flush in IDLE blocks acceptance.
        @(negedge clk);
        flush_i = 1'b1;
        req_valid_i = 1'b1;
        funct3_i = F_DIV;
        rs1_i = 32'd5;
        rs2_i = 32'd0;
        #1 check("flush_idle_ready", {31'd0, req_ready_o}, 32'd0);
        @(posedge clk);
        #1 flush_i = 1'b0;
        req_valid_i = 1'b0;
        @(negedge clk);
        check("flush_idle_no_resp", {31'd0, resp_valid_o}, 32'd0);

        // Flush in WAIT 10 cycles after accept: no response, drain until done.
        s0 = start_cnt;
        do_req(F_DIV, 32'd1000, 32'd3, 32'd0, 1'b0, acc);
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        expect_drain("flush");
        check("flush_start_pulses", start_cnt - s0, 32'd1);
        v = '{F_DIVU, 32'd100, 32'd7, 32'd14, 35, 1, 0};
        run_vec(v);

        // Reset mid-division: reset values, drain until the core's done, then resume.
        do_req(F_DIV, 32'd1000, 32'd3, 32'd0, 1'b0, acc);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset_vals();
        repeat (2) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        #1 check("rst_mid_ready_low", {31'd0, req_ready_o}, 32'd0);
        expect_drain("reset");
        v = '{F_DIV, 32'd9, 32'd3, 32'd3, 35, 1, 0};
        run_vec(v);

        check("core_start_while_busy", start_busy_err, 32'd0);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the bench always reaches its summary line.
    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
